jzjpcc_mem_access_sequencer: RTL and testbench
==============================================

Name: jzjpcc_mem_access_sequencer

Overview:
- Sequences the data-memory port for loads and stores issued by the memory stage.
- Generates the per-access byte mask, shifts write data into byte lanes, and extracts plus sign/zero-extends load data.
- Splits accesses that cross a word boundary into two aligned word accesses, holding the pipeline stalled until the access completes.
- Sits between the memory-stage pipeline registers and the single-port synchronous data RAM.

Parameters:
- ADDR_WIDTH, 32: byte-address width. The word-address output is ADDR_WIDTH-2 bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- memRequest_memory  in  1  load/store request; held until memAck_memory
- memWrite_memory  in  1  1 = store, 0 = load
- funct3_memory  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- memAddress_memory  in  ADDR_WIDTH  byte address (ALU result)
- rs2_memory  in  32  store data
- memAck_memory  out  1  one-cycle completion pulse
- memLoadResult_memory  out  32  extended load result; valid only while memAck_memory=1
- misalignedFault_memory  out  1  completion without access; pulses with memAck_memory
- stall_memory  out  1  memRequest_memory & ~memAck_memory
- dmemWordAddress  out  ADDR_WIDTH-2  RAM word address
- dmemByteMask  out  4  byte-lane enables, bit i = byte lane i
- dmemWriteData  out  32  lane-aligned write data
- dmemEnable  out  1  RAM access this cycle
- dmemWriteEnable  out  1  store this cycle; only asserted with dmemEnable
- dmemReadData  in  32  RAM read data; 1-cycle latency, returned in the cycle after dmemEnable

Behaviour:
- States: IDLE, ACC_LO, ACC_HI, RESP.
- Reset values: state = IDLE. All outputs are 0: ack, fault, dmemEnable, dmemWriteEnable, mask, address, write data, load result.
- IDLE, no request: no memory access.
- IDLE, memRequest_memory=1: latch write, funct3, address and rs2.
  - off = addr[1:0]; base mask = 0001 (B), 0011 (H), 1111 (W).
  - crossing = (H and off=3) or (W and off≠0).
  - Illegal funct3 (011, 110, 111, or a store with 1xx): go to RESP with fault=1. No RAM access.
  - Otherwise go to ACC_LO.
- ACC_LO:
  - dmemEnable=1; word address = addr[ADDR_WIDTH-1:2].
  - Mask = (base << off)[3:0]; write data = rs2 << 8*off.
  - dmemWriteEnable = latched write.
  - Next state: ACC_HI if crossing, else RESP.
- ACC_HI:
  - dmemEnable=1; word address = low word address + 1, wrapping to 0 at the all-ones address.
  - Mask = base >> (4-off); write data = rs2 >> 8*(4-off).
  - Low-word read data is captured into a holding register this cycle.
  - Next state: RESP.
- RESP:
  - memAck_memory=1 for exactly this cycle; next state IDLE.
  - Load result = ({hi,lo} >> 8*off), truncated to the access width, then extended:
    - B/H sign-extend; BU/HU zero-extend; W passes through.
    - lo = holding register if crossing, else dmemReadData. hi = dmemReadData.
  - Stores return a load result of 0.
- Latency from request-accept cycle to ack: aligned access 2 cycles, crossing access 3 cycles, illegal funct3 1 cycle.
- Input changes after the accept cycle are ignored; the request is latched.
- memRequest_memory still high in the cycle after ack is treated as a new request, so back-to-back accesses are supported.
- Reset mid-operation: return to IDLE immediately, no ack is issued, and the request is dropped.
  - If reset arrives in ACC_HI, the low half of a split store is already written and the high half is not. This is accepted; the pipeline is flushed on reset.
- Byte lanes not covered by the mask are don't-care in dmemWriteData but are driven 0.

Optional Feature:
- Macro: JZJPCC_MISALIGNED_SPLIT_EN.
- Defined: crossing accesses are split as described above; misalignedFault_memory pulses only for illegal funct3.
- Undefined: a crossing access makes no RAM access. It goes IDLE→RESP with fault=1, result 0, 1-cycle latency, and the ACC_HI state logic is removed.
- Non-crossing misaligned accesses (e.g. LH at off=1, LB anywhere) are unaffected in both builds.

Test Plan:
- Aligned LW at 0x100, RAM word 64 = 0xDEADBEEF:
  - one access with mask 1111, word address 0x40;
  - ack 2 cycles after accept; result 0xDEADBEEF.
- LB at 0x103 with word = 0x80112233:
  - mask 1000; result 0xFFFFFF80.
  - Repeat with LBU: result 0x00000080.
- SH at 0x102, rs2=0x0000ABCD:
  - single access, mask 1100, write data 0xABCD0000;
  - ack at +2, fault 0.
- With split enabled, SW at 0x0FE, rs2=0x11223344:
  - access 1: word 0x3F, mask 1100, data 0x33440000;
  - access 2: word 0x40, mask 0011, data 0x00001122;
  - ack at +3.
- With split enabled, LW at 0xFFFFFFFF:
  - second access at word address 0;
  - result assembled as {word0[23:0], wordTop[31:24]}.
- Reset asserted in ACC_HI of a split store:
  - next cycle IDLE, no ack, dmemEnable=0.
  - Separately, funct3=011 gives ack+fault at +1 with no dmemEnable.

Source files
------------

// File: rtl/jzjpcc_mem_access_sequencer.sv
// jzjpcc_mem_access_sequencer
// Drives the single-port synchronous data RAM for loads and stores from the
// memory stage: byte masks, lane-aligned write data, load extraction and
// extension, and splitting of word-crossing accesses into two RAM accesses.
// Build option: define JZJPCC_MISALIGNED_SPLIT_EN to split crossing accesses;
// without it a crossing access completes immediately with a fault.
module jzjpcc_mem_access_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRequest_memory,
  input  logic                  memWrite_memory,
  input  logic [2:0]            funct3_memory,
  input  logic [ADDR_WIDTH-1:0] memAddress_memory,
  input  logic [31:0]           rs2_memory,
  output logic                  memAck_memory,
  output logic [31:0]           memLoadResult_memory,
  output logic                  misalignedFault_memory,
  output logic                  stall_memory,
  output logic [ADDR_WIDTH-3:0] dmemWordAddress,
  output logic [3:0]            dmemByteMask,
  output logic [31:0]           dmemWriteData,
  output logic                  dmemEnable,
  output logic                  dmemWriteEnable,
  input  logic [31:0]           dmemReadData
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

  state_t                state, state_nxt;
  logic                  write_p0;
  logic [2:0]            funct3_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [31:0]           rs2_p0;
  logic                  fault_p0;

  logic                  accept;
  logic                  fault_in;
  logic [1:0]            off_p0;
  logic [3:0]            base_p0;
  logic [ADDR_WIDTH-3:0] word_lo;
  logic [3:0]            mask_lo;
  logic [31:0]           wdata_lo;
  logic [31:0]           rdata_lo;
  logic [31:0]           load_raw;

  // Lanes touched by an aligned access of the given width.
  function automatic logic [3:0] base_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when the access spills past the end of its 32-bit word.
  function automatic logic is_crossing(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'd3)) ||
           ((f3[1:0] == 2'b10) && (off != 2'd0));
  endfunction

  // Encodings with no RV32I load/store meaning, including unsigned stores.
  function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
  endfunction

  // Truncate to the access width, then sign- or zero-extend.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    b  = raw[7:0];
    h  = raw[15:0];
    sx = 32'sd0;
    case (f3)
      3'b000:  sx = b;
      3'b001:  sx = h;
      3'b010:  sx = raw;
      3'b100:  sx = {24'd0, raw[7:0]};
      3'b101:  sx = {16'd0, raw[15:0]};
      default: sx = 32'sd0;
    endcase
    return sx;
  endfunction

  assign accept = (state == IDLE) && memRequest_memory;
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
  assign fault_in = is_illegal(memWrite_memory, funct3_memory);
`else
  assign fault_in = is_illegal(memWrite_memory, funct3_memory) ||
                    is_crossing(funct3_memory, memAddress_memory[1:0]);
`endif

  assign off_p0   = addr_p0[1:0];
  assign base_p0  = base_mask(funct3_p0);
  assign word_lo  = addr_p0[ADDR_WIDTH-1:2];
  assign mask_lo  = base_p0 << off_p0;
  assign wdata_lo = rs2_p0 << {off_p0, 3'b000};
  assign stall_memory = memRequest_memory & ~memAck_memory;

`ifdef JZJPCC_MISALIGNED_SPLIT_EN
  logic                  cross_p0;
  logic [ADDR_WIDTH-3:0] word_hi;
  logic [3:0]            mask_hi;
  logic [31:0]           wdata_hi;
  logic [31:0]           hold_p1;

  assign cross_p0 = is_crossing(funct3_p0, off_p0);
  // Wraps to word 0 past the all-ones address.
  assign word_hi  = word_lo + (ADDR_WIDTH-2)'(1);
  assign mask_hi  = base_p0 >> (3'd4 - {1'b0, off_p0});
  // Shift by 8*(4-off); off is never 0 here, so the amount fits in 5 bits.
  assign wdata_hi = rs2_p0 >> 5'(6'd32 - {1'b0, off_p0, 3'b000});
  assign rdata_lo = cross_p0 ? hold_p1 : dmemReadData;

  // Low-word read data arrives during ACC_HI; keep it for assembly in RESP.
  always_ff @(posedge clock) begin
    if (state == ACC_HI)
      hold_p1 <= dmemReadData;
  end
`else
  assign rdata_lo = dmemReadData;
`endif

  assign load_raw = 32'({dmemReadData, rdata_lo} >> {off_p0, 3'b000});

  // Control state and the fault flag; only these are reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fault_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        fault_p0 <= fault_in;
    end
  end

  // Request latch: inputs are captured once, in the accept cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0  <= memWrite_memory;
      funct3_p0 <= funct3_memory;
      addr_p0   <= memAddress_memory;
      rs2_p0    <= rs2_memory;
    end
  end

  // Next-state and RAM/pipeline outputs; everything idles at zero.
  always_comb begin
    state_nxt              = state;
    memAck_memory          = 1'b0;
    misalignedFault_memory = 1'b0;
    memLoadResult_memory   = 32'd0;
    dmemEnable             = 1'b0;
    dmemWriteEnable        = 1'b0;
    dmemWordAddress        = '0;
    dmemByteMask           = 4'd0;
    dmemWriteData          = 32'd0;
    case (state)
      IDLE: begin
        if (memRequest_memory)
          state_nxt = fault_in ? RESP : ACC_LO;
      end
      ACC_LO: begin
        dmemEnable      = 1'b1;
        dmemWriteEnable = write_p0;
        dmemWordAddress = word_lo;
        dmemByteMask    = mask_lo;
        dmemWriteData   = wdata_lo;
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
        state_nxt       = cross_p0 ? ACC_HI : RESP;
`else
        state_nxt       = RESP;
`endif
      end
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
      ACC_HI: begin
        dmemEnable      = 1'b1;
        dmemWriteEnable = write_p0;
        dmemWordAddress = word_hi;
        dmemByteMask    = mask_hi;
        dmemWriteData   = wdata_hi;
        state_nxt       = RESP;
      end
`endif
      RESP: begin
        memAck_memory          = 1'b1;
        misalignedFault_memory = fault_p0;
        if (!write_p0 && !fault_p0)
          memLoadResult_memory = extend_load(funct3_p0, load_raw);
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jzjpcc_mem_access_sequencer.sv
// Directed bench for jzjpcc_mem_access_sequencer with a behavioural
// synchronous RAM. Expectations follow JZJPCC_MISALIGNED_SPLIT_EN.
module tb_jzjpcc_mem_access_sequencer;

  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          memRequest_memory;
  logic          memWrite_memory;
  logic [2:0]    funct3_memory;
  logic [AW-1:0] memAddress_memory;
  logic [31:0]   rs2_memory;
  logic          memAck_memory;
  logic [31:0]   memLoadResult_memory;
  logic          misalignedFault_memory;
  logic          stall_memory;
  logic [AW-3:0] dmemWordAddress;
  logic [3:0]    dmemByteMask;
  logic [31:0]   dmemWriteData;
  logic          dmemEnable;
  logic          dmemWriteEnable;
  logic [31:0]   dmemReadData = 32'd0;

  jzjpcc_mem_access_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .memRequest_memory      (memRequest_memory),
    .memWrite_memory        (memWrite_memory),
    .funct3_memory          (funct3_memory),
    .memAddress_memory      (memAddress_memory),
    .rs2_memory             (rs2_memory),
    .memAck_memory          (memAck_memory),
    .memLoadResult_memory   (memLoadResult_memory),
    .misalignedFault_memory (misalignedFault_memory),
    .stall_memory           (stall_memory),
    .dmemWordAddress        (dmemWordAddress),
    .dmemByteMask           (dmemByteMask),
    .dmemWriteData          (dmemWriteData),
    .dmemEnable             (dmemEnable),
    .dmemWriteEnable        (dmemWriteEnable),
    .dmemReadData           (dmemReadData)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: read-before-write, one-cycle read latency.
  logic [31:0] ram [logic [29:0]];
  logic [31:0] wtmp;
  always @(posedge clock) begin
    if (dmemEnable) begin
      dmemReadData <= ram.exists(dmemWordAddress) ? ram[dmemWordAddress] : 32'd0;
      if (dmemWriteEnable) begin
        wtmp = ram.exists(dmemWordAddress) ? ram[dmemWordAddress] : 32'd0;
        for (int i = 0; i < 4; i++)
          if (dmemByteMask[i]) wtmp[8*i +: 8] = dmemWriteData[8*i +: 8];
        ram[dmemWordAddress] = wtmp;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the most recent run_access.
  int          acc_n;
  logic [31:0] acc_addr [4];
  logic [3:0]  acc_mask [4];
  logic [31:0] acc_data [4];
  logic        acc_we   [4];
  int          ack_at;
  logic [31:0] res;
  logic        flt;
  logic        stall0;

  // One transaction; cycle 0 is the accept cycle. Inputs are scrambled
  // after acceptance since the request is latched.
  task automatic run_access(input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data);
    @(posedge clock); #1;
    memRequest_memory = 1'b1;
    memWrite_memory   = wr;
    funct3_memory     = f3;
    memAddress_memory = addr;
    rs2_memory        = data;
    acc_n  = 0;
    ack_at = -1;
    res    = 32'hxxxxxxxx;
    flt    = 1'bx;
    for (int i = 0; i < 4; i++) begin
      acc_addr[i] = 32'd0; acc_mask[i] = 4'd0; acc_data[i] = 32'd0; acc_we[i] = 1'b0;
    end
    for (int n = 0; n < 10 && ack_at < 0; n++) begin
      @(negedge clock);
      if (n == 0) stall0 = stall_memory;
      if (dmemEnable && acc_n < 4) begin
        acc_addr[acc_n] = {2'b00, dmemWordAddress};
        acc_mask[acc_n] = dmemByteMask;
        acc_data[acc_n] = dmemWriteData;
        acc_we[acc_n]   = dmemWriteEnable;
        acc_n++;
      end
      if (n == 1) begin
        memWrite_memory   = ~wr;
        funct3_memory     = 3'b111;
        memAddress_memory = ~addr;
        rs2_memory        = ~data;
      end
      if (memAck_memory) begin
        ack_at = n;
        res    = memLoadResult_memory;
        flt    = misalignedFault_memory;
        memRequest_memory = 1'b0;
      end
    end
    memRequest_memory = 1'b0;
  endtask

  int t_first;
  int t_second;

`ifdef JZJPCC_MISALIGNED_SPLIT_EN
  localparam int          RST_AT   = 2;
  localparam logic [31:0] RST_ADDR = 32'h0000_00FE;
  localparam logic [31:0] RST_WORD = 32'h0000_0040;
`else
  localparam int          RST_AT   = 1;
  localparam logic [31:0] RST_ADDR = 32'h0000_0200;
  localparam logic [31:0] RST_WORD = 32'h0000_0080;
`endif

  initial begin
    reset = 1'b1;
    memRequest_memory = 1'b0;
    memWrite_memory   = 1'b0;
    funct3_memory     = 3'b000;
    memAddress_memory = 32'd0;
    rs2_memory        = 32'd0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_ack",   {31'd0, memAck_memory}, 32'd0);
    chk("rst_fault", {31'd0, misalignedFault_memory}, 32'd0);
    chk("rst_en",    {31'd0, dmemEnable}, 32'd0);
    chk("rst_we",    {31'd0, dmemWriteEnable}, 32'd0);
    chk("rst_mask",  {28'd0, dmemByteMask}, 32'd0);
    chk("rst_addr",  {2'b00, dmemWordAddress}, 32'd0);
    chk("rst_wdata", dmemWriteData, 32'd0);
    chk("rst_res",   memLoadResult_memory, 32'd0);
    chk("rst_stall", {31'd0, stall_memory}, 32'd0);
    reset = 1'b0;

    ram[30'h40] = 32'hDEADBEEF;
    ram[30'h90] = 32'h12345678;

    // Aligned LW
    run_access(1'b0, 3'b010, 32'h100, 32'd0);
    chk("lw_stall", {31'd0, stall0}, 32'd1);
    chk("lw_nacc",  acc_n, 32'd1);
    chk("lw_addr",  acc_addr[0], 32'h40);
    chk("lw_mask",  {28'd0, acc_mask[0]}, 32'hF);
    chk("lw_we",    {31'd0, acc_we[0]}, 32'd0);
    chk("lw_lat",   ack_at, 32'd2);
    chk("lw_res",   res, 32'hDEADBEEF);
    chk("lw_fault", {31'd0, flt}, 32'd0);

    // Byte and halfword loads, including non-crossing misaligned ones
    ram[30'h40] = 32'h80112233;
    run_access(1'b0, 3'b000, 32'h103, 32'd0);
    chk("lb_mask", {28'd0, acc_mask[0]}, 32'h8);
    chk("lb_res",  res, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h103, 32'd0);
    chk("lbu_res", res, 32'h00000080);
    run_access(1'b0, 3'b001, 32'h102, 32'd0);
    chk("lh_mask", {28'd0, acc_mask[0]}, 32'hC);
    chk("lh_res",  res, 32'hFFFF8011);
    run_access(1'b0, 3'b101, 32'h101, 32'd0);
    chk("lhu1_mask",  {28'd0, acc_mask[0]}, 32'h6);
    chk("lhu1_lat",   ack_at, 32'd2);
    chk("lhu1_fault", {31'd0, flt}, 32'd0);
    chk("lhu1_res",   res, 32'h00001122);

    // SH at 0x102
    run_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
    chk("sh_nacc",  acc_n, 32'd1);
    chk("sh_addr",  acc_addr[0], 32'h40);
    chk("sh_mask",  {28'd0, acc_mask[0]}, 32'hC);
    chk("sh_data",  acc_data[0], 32'hABCD0000);
    chk("sh_we",    {31'd0, acc_we[0]}, 32'd1);
    chk("sh_lat",   ack_at, 32'd2);
    chk("sh_fault", {31'd0, flt}, 32'd0);
    chk("sh_res",   res, 32'd0);
    run_access(1'b0, 3'b010, 32'h100, 32'd0);
    chk("sh_readback", res, 32'hABCD2233);

    // Back-to-back: request stays high through the first ack
    @(posedge clock); #1;
    memRequest_memory = 1'b1;
    memWrite_memory   = 1'b0;
    funct3_memory     = 3'b010;
    memAddress_memory = 32'h240;
    t_first  = -1;
    t_second = -1;
    for (int n = 0; n < 12 && t_second < 0; n++) begin
      @(negedge clock);
      if (memAck_memory && t_first < 0) begin
        t_first = n;
        chk("b2b_res1", memLoadResult_memory, 32'h12345678);
        memAddress_memory = 32'h100;
      end else if (memAck_memory) begin
        t_second = n;
        chk("b2b_res2", memLoadResult_memory, 32'hABCD2233);
      end
    end
    memRequest_memory = 1'b0;
    chk("b2b_gap", t_second - t_first, 32'd3);

    // Word-crossing SW at 0x0FE
    ram[30'h3F] = 32'd0;
    run_access(1'b1, 3'b010, 32'h0FE, 32'h11223344);
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
    chk("swx_nacc",  acc_n, 32'd2);
    chk("swx_addr0", acc_addr[0], 32'h3F);
    chk("swx_mask0", {28'd0, acc_mask[0]}, 32'hC);
    chk("swx_data0", acc_data[0], 32'h33440000);
    chk("swx_addr1", acc_addr[1], 32'h40);
    chk("swx_mask1", {28'd0, acc_mask[1]}, 32'h3);
    chk("swx_data1", acc_data[1], 32'h00001122);
    chk("swx_we1",   {31'd0, acc_we[1]}, 32'd1);
    chk("swx_lat",   ack_at, 32'd3);
    chk("swx_fault", {31'd0, flt}, 32'd0);
`else
    chk("swx_nacc",  acc_n, 32'd0);
    chk("swx_lat",   ack_at, 32'd1);
    chk("swx_fault", {31'd0, flt}, 32'd1);
    chk("swx_res",   res, 32'd0);
`endif

    // Crossing LW at the top of the address space
    ram[30'h3FFFFFFF] = 32'hAABBCCDD;
    ram[30'h0]        = 32'h11223344;
    run_access(1'b0, 3'b010, 32'hFFFFFFFF, 32'd0);
`ifdef JZJPCC_MISALIGNED_SPLIT_EN
    chk("lwtop_nacc",  acc_n, 32'd2);
    chk("lwtop_addr0", acc_addr[0], 32'h3FFFFFFF);
    chk("lwtop_mask0", {28'd0, acc_mask[0]}, 32'h8);
    chk("lwtop_addr1", acc_addr[1], 32'h0);
    chk("lwtop_mask1", {28'd0, acc_mask[1]}, 32'h7);
    chk("lwtop_lat",   ack_at, 32'd3);
    chk("lwtop_res",   res, 32'h223344AA);
`else
    chk("lwtop_nacc",  acc_n, 32'd0);
    chk("lwtop_fault", {31'd0, flt}, 32'd1);
    chk("lwtop_res",   res, 32'd0);
`endif

    // Illegal encodings
    run_access(1'b0, 3'b011, 32'h100, 32'd0);
    chk("ill_nacc",  acc_n, 32'd0);
    chk("ill_lat",   ack_at, 32'd1);
    chk("ill_fault", {31'd0, flt}, 32'd1);
    chk("ill_res",   res, 32'd0);
    run_access(1'b1, 3'b100, 32'h100, 32'h55);
    chk("illst_nacc",  acc_n, 32'd0);
    chk("illst_fault", {31'd0, flt}, 32'd1);

    // Reset in the middle of a store
    @(posedge clock); #1;
    memRequest_memory = 1'b1;
    memWrite_memory   = 1'b1;
    funct3_memory     = 3'b010;
    memAddress_memory = RST_ADDR;
    rs2_memory        = 32'hCAFEF00D;
    for (int n = 0; n <= RST_AT; n++) begin
      @(negedge clock);
      if (n == RST_AT) begin
        chk("rstmid_en",   {31'd0, dmemEnable}, 32'd1);
        chk("rstmid_addr", {2'b00, dmemWordAddress}, RST_WORD);
        reset = 1'b1;
        memRequest_memory = 1'b0;
      end
    end
    @(negedge clock);
    chk("rstmid_ack",   {31'd0, memAck_memory}, 32'd0);
    chk("rstmid_en2",   {31'd0, dmemEnable}, 32'd0);
    chk("rstmid_fault", {31'd0, misalignedFault_memory}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_ack2", {31'd0, memAck_memory}, 32'd0);
    chk("rstmid_en3",  {31'd0, dmemEnable}, 32'd0);

    // Normal operation resumes after reset
    run_access(1'b0, 3'b010, 32'h240, 32'd0);
    chk("post_lat", ack_at, 32'd2);
    chk("post_res", res, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
